// File: rtl/frame_buffer_ring_if.sv
// Bundle between a frame_buffer_ring and its pixel producer / scan-out consumer:
// pixel read and write ports, frame hand-off pulses and slot/statistics status.
interface frame_buffer_ring_if #(
    parameter int unsigned NUM_BUFFERS = 3,
    parameter int unsigned PIXEL_WIDTH = 24,
    parameter int unsigned COORD_WIDTH = 21
);
    localparam int unsigned SLOT_WIDTH = $clog2(NUM_BUFFERS);

    logic                   endOfRead;
    logic                   endOfWrite;
    logic                   ableToRead;
    logic                   ableToWrite;
    logic                   readPixelSignal;
    logic [COORD_WIDTH-1:0] readPixelX;
    logic [COORD_WIDTH-1:0] readPixelY;
    logic [PIXEL_WIDTH-1:0] readPixel;
    logic                   readPixelValid;
    logic                   writePixelSignal;
    logic [COORD_WIDTH-1:0] writePixelX;
    logic [COORD_WIDTH-1:0] writePixelY;
    logic [PIXEL_WIDTH-1:0] writePixel;
    logic [SLOT_WIDTH-1:0]  currentRead;
    logic [SLOT_WIDTH-1:0]  currentWrite;
    logic [15:0]            droppedFrames;
    logic [15:0]            repeatedFrames;

    modport master (
        output endOfRead, endOfWrite, readPixelSignal, readPixelX, readPixelY,
               writePixelSignal, writePixelX, writePixelY, writePixel,
        input  ableToRead, ableToWrite, readPixel, readPixelValid, currentRead, currentWrite,
               droppedFrames, repeatedFrames
    );

    modport slave (
        input  endOfRead, endOfWrite, readPixelSignal, readPixelX, readPixelY,
               writePixelSignal, writePixelX, writePixelY, writePixel,
        output ableToRead, ableToWrite, readPixel, readPixelValid, currentRead, currentWrite,
               droppedFrames, repeatedFrames
    );
endinterface

// File: rtl/frame_buffer_ring.sv
// N-slot frame buffer: hands the writer a free slot and the reader the newest completed frame,
// clears slot 0 after reset and counts dropped and repeated frames.
module frame_buffer_ring #(
    parameter int unsigned NUM_BUFFERS = 3,
    parameter int unsigned PIXEL_WIDTH = 24,
    parameter int unsigned H_RES = 1920,
    parameter int unsigned V_RES = 1080,
    parameter int unsigned COORD_WIDTH = 21,
    parameter logic [PIXEL_WIDTH-1:0] FILL_VALUE = PIXEL_WIDTH'(24'hFFFFFF)
) (
    input logic clk,
    input logic reset,
    frame_buffer_ring_if.slave bus
);
    localparam int unsigned FRAME_SIZE = H_RES * V_RES;
    localparam int unsigned MEM_DEPTH = NUM_BUFFERS * FRAME_SIZE;
    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int unsigned SLOT_WIDTH = $clog2(NUM_BUFFERS);
    localparam int unsigned FILL_WIDTH = $clog2(FRAME_SIZE + 1);
    localparam logic [COORD_WIDTH-1:0] X_LIMIT = COORD_WIDTH'(H_RES);
    localparam logic [COORD_WIDTH-1:0] Y_LIMIT = COORD_WIDTH'(V_RES);
    localparam logic [FILL_WIDTH-1:0] FILL_DONE = FILL_WIDTH'(FRAME_SIZE);

    typedef logic [SLOT_WIDTH-1:0] SlotIdx;
    typedef enum logic {StInit, StRun} FsmState;
    typedef enum logic [1:0] {SlotFree, SlotWriting, SlotReady, SlotReading} SlotState;

    FsmState                stateQ, stateD;
    logic [FILL_WIDTH-1:0]  fillCountQ, fillCountD;
    SlotState               slotStateQ [NUM_BUFFERS];
    SlotState               slotStateD [NUM_BUFFERS];
    SlotIdx                 currentReadQ, currentReadD;
    SlotIdx                 currentWriteQ, currentWriteD;
    logic [15:0]            droppedQ, droppedD;
    logic [15:0]            repeatedQ, repeatedD;
    logic [PIXEL_WIDTH-1:0] readPixelQ;
    logic                   readValidQ;

    logic [PIXEL_WIDTH-1:0] frameMem [MEM_DEPTH];
    logic                   memWe;
    logic [ADDR_WIDTH-1:0]  memWAddr;
    logic [PIXEL_WIDTH-1:0] memWData;

    logic   run, fillWrite;
    logic   readAccept, readInRange, writeInRange;
    logic   readyFound;
    SlotIdx readyIdx, freeIdx;

    function automatic logic [ADDR_WIDTH-1:0] pixelAddr(input SlotIdx slot,
                                                        input logic [COORD_WIDTH-1:0] x,
                                                        input logic [COORD_WIDTH-1:0] y);
        return ADDR_WIDTH'(slot) * ADDR_WIDTH'(FRAME_SIZE)
             + ADDR_WIDTH'(y) * ADDR_WIDTH'(H_RES) + ADDR_WIDTH'(x);
    endfunction

    assign run          = (stateQ == StRun);
    assign fillWrite    = (stateQ == StInit) && (fillCountQ != FILL_DONE);
    assign readAccept   = run && bus.readPixelSignal;
    assign readInRange  = (bus.readPixelX < X_LIMIT) && (bus.readPixelY < Y_LIMIT);
    assign writeInRange = (bus.writePixelX < X_LIMIT) && (bus.writePixelY < Y_LIMIT);

    // INIT holds one extra cycle after the last fill write before handing over.
    always_comb begin
        stateD     = stateQ;
        fillCountD = fillCountQ;
        case (stateQ)
            StInit: begin
                if (fillCountQ == FILL_DONE) begin
                    stateD = StRun;
                end else begin
                    fillCountD = fillCountQ + FILL_WIDTH'(1);
                end
            end
            StRun:   stateD = StRun;
            default: stateD = StInit;
        endcase
    end

    always_comb begin
        memWe    = 1'b0;
        memWAddr = '0;
        memWData = '0;
        if (fillWrite) begin
            memWe    = 1'b1;
            memWAddr = ADDR_WIDTH'(fillCountQ);
            memWData = FILL_VALUE;
        end else if (run && bus.writePixelSignal && writeInRange) begin
            memWe    = 1'b1;
            memWAddr = pixelAddr(currentWriteQ, bus.writePixelX, bus.writePixelY);
            memWData = bus.writePixel;
        end
    end

    // Read release is resolved before write completion, against the pre-edge READY slot.
    always_comb begin
        slotStateD    = slotStateQ;
        currentReadD  = currentReadQ;
        currentWriteD = currentWriteQ;
        droppedD      = droppedQ;
        repeatedD     = repeatedQ;
        readyFound    = 1'b0;
        readyIdx      = '0;
        freeIdx       = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (slotStateQ[i] == SlotReady) begin
                readyFound = 1'b1;
                readyIdx   = SlotIdx'(i);
            end
        end
        if (run && bus.endOfRead) begin
            if (readyFound) begin
                slotStateD[currentReadQ] = SlotFree;
                slotStateD[readyIdx]     = SlotReading;
                currentReadD             = readyIdx;
            end else if (repeatedQ != 16'hFFFF) begin
                repeatedD = repeatedQ + 16'd1;
            end
        end
        if (run && bus.endOfWrite) begin
            slotStateD[currentWriteQ] = SlotReady;
            if (readyFound && !bus.endOfRead) begin
                slotStateD[readyIdx] = SlotFree;
                if (droppedQ != 16'hFFFF) begin
                    droppedD = droppedQ + 16'd1;
                end
            end
            for (int i = int'(NUM_BUFFERS) - 1; i >= 0; i--) begin
                if (slotStateD[i] == SlotFree) begin
                    freeIdx = SlotIdx'(i);
                end
            end
            slotStateD[freeIdx] = SlotWriting;
            currentWriteD       = freeIdx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ        <= StInit;
            fillCountQ    <= '0;
            currentReadQ  <= '0;
            currentWriteQ <= SlotIdx'(1);
            droppedQ      <= '0;
            repeatedQ     <= '0;
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                slotStateQ[i] <= (i == 0) ? SlotReading : (i == 1) ? SlotWriting : SlotFree;
            end
        end else begin
            stateQ        <= stateD;
            fillCountQ    <= fillCountD;
            currentReadQ  <= currentReadD;
            currentWriteQ <= currentWriteD;
            droppedQ      <= droppedD;
            repeatedQ     <= repeatedD;
            slotStateQ    <= slotStateD;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            frameMem[memWAddr] <= memWData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readPixelQ <= '0;
            readValidQ <= 1'b0;
        end else begin
            readValidQ <= readAccept;
            if (readAccept) begin
                readPixelQ <= readInRange
                    ? frameMem[pixelAddr(currentReadQ, bus.readPixelX, bus.readPixelY)] : '0;
            end
        end
    end

    assign bus.ableToRead     = run;
    assign bus.ableToWrite    = run;
    assign bus.readPixel      = readPixelQ;
    assign bus.readPixelValid = readValidQ;
    assign bus.currentRead    = currentReadQ;
    assign bus.currentWrite   = currentWriteQ;
    assign bus.droppedFrames  = droppedQ;
    assign bus.repeatedFrames = repeatedQ;
endmodule

// File: tb/tb_frame_buffer_ring.sv
// Bench for frame_buffer_ring: directed vector table, init/reset sequences and randomized
// traffic compared against a queue-based ownership model.
module tb_frame_buffer_ring;
    localparam int NB = 3;
    localparam int PW = 24;
    localparam int HR = 4;
    localparam int VR = 2;
    localparam int CW = 21;
    localparam int FRAME = HR * VR;
    localparam int TOTAL = NB * FRAME;
    localparam logic [PW-1:0] FILL = 24'hFFFFFF;

    logic clk;
    logic reset;

    frame_buffer_ring_if #(.NUM_BUFFERS(NB), .PIXEL_WIDTH(PW), .COORD_WIDTH(CW)) bus ();

    frame_buffer_ring #(
        .NUM_BUFFERS(NB), .PIXEL_WIDTH(PW), .H_RES(HR), .V_RES(VR),
        .COORD_WIDTH(CW), .FILL_VALUE(FILL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    // Stimulus copies so the model never reads back through the DUT.
    bit inEor, inEow, inRs, inWs;
    int inRx, inRy, inWx, inWy;
    logic [PW-1:0] inWd;

    // Reference model: pixel store plus slot ownership as plain indices and a READY queue.
    logic [PW-1:0] refMem [TOTAL];
    bit refKnown [TOTAL];
    int mRead, mWrite, mDropped, mRepeated, mFill;
    int mReady [$];
    bit mRun, mValid, mPixelKnown;
    logic [PW-1:0] mPixel;

    typedef struct {
        bit eor; bit eow; bit rs; int rx; int ry; bit ws; int wx; int wy; int wd;
        int eRead; int eWrite; int eDrop; int eRep; bit eValid; int ePixel;
    } vec_t;
    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic setIn(input bit eor, input bit eow, input bit rs, input int rx, input int ry,
                         input bit ws, input int wx, input int wy, input logic [PW-1:0] wd);
        inEor = eor; inEow = eow; inRs = rs; inRx = rx; inRy = ry;
        inWs = ws; inWx = wx; inWy = wy; inWd = wd;
        bus.endOfRead = eor;
        bus.endOfWrite = eow;
        bus.readPixelSignal = rs;
        bus.readPixelX = CW'(rx);
        bus.readPixelY = CW'(ry);
        bus.writePixelSignal = ws;
        bus.writePixelX = CW'(wx);
        bus.writePixelY = CW'(wy);
        bus.writePixel = wd;
    endtask

    task automatic modelReset();
        mRead = 0; mWrite = 1; mDropped = 0; mRepeated = 0; mFill = 0;
        mReady.delete();
        mRun = 0; mValid = 0; mPixel = '0; mPixelKnown = 1;
    endtask

    function automatic bit isReady(input int s);
        foreach (mReady[i]) if (mReady[i] == s) return 1;
        return 0;
    endfunction

    function automatic int lowestFree();
        for (int s = 0; s < NB; s++) if (s != mRead && !isReady(s)) return s;
        return -1;
    endfunction

    task automatic modelStep();
        int a;
        if (!reset) begin
            modelReset();
            return;
        end
        if (!mRun) begin
            mValid = 0;
            if (mFill < FRAME) begin
                refMem[mFill] = FILL;
                refKnown[mFill] = 1;
                mFill++;
            end else begin
                mRun = 1;
            end
            return;
        end
        mValid = inRs;
        if (inRs) begin
            if (inRx < HR && inRy < VR) begin
                a = mRead * FRAME + inRy * HR + inRx;
                mPixel = refMem[a];
                mPixelKnown = refKnown[a];
            end else begin
                mPixel = '0;
                mPixelKnown = 1;
            end
        end
        if (inWs && inWx < HR && inWy < VR) begin
            a = mWrite * FRAME + inWy * HR + inWx;
            refMem[a] = inWd;
            refKnown[a] = 1;
        end
        if (inEor) begin
            if (mReady.size() > 0) mRead = mReady.pop_front();
            else if (mRepeated < 16'hFFFF) mRepeated++;
        end
        if (inEow) begin
            if (mReady.size() > 0) begin
                void'(mReady.pop_front());
                if (mDropped < 16'hFFFF) mDropped++;
            end
            mReady.push_back(mWrite);
            mWrite = lowestFree();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkAll(input string tag);
        check({tag, " currentRead"}, 32'(bus.currentRead), mRead);
        check({tag, " currentWrite"}, 32'(bus.currentWrite), mWrite);
        check({tag, " droppedFrames"}, 32'(bus.droppedFrames), mDropped);
        check({tag, " repeatedFrames"}, 32'(bus.repeatedFrames), mRepeated);
        check({tag, " ableToRead"}, 32'(bus.ableToRead), 32'(mRun));
        check({tag, " readPixelValid"}, 32'(bus.readPixelValid), 32'(mValid));
        if (mValid && mPixelKnown) check({tag, " readPixel"}, 32'(bus.readPixel), 32'(mPixel));
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, " ableToRead"}, 32'(bus.ableToRead), 0);
        check({tag, " ableToWrite"}, 32'(bus.ableToWrite), 0);
        check({tag, " readPixel"}, 32'(bus.readPixel), 0);
        check({tag, " readPixelValid"}, 32'(bus.readPixelValid), 0);
        check({tag, " currentRead"}, 32'(bus.currentRead), 0);
        check({tag, " currentWrite"}, 32'(bus.currentWrite), 1);
        check({tag, " droppedFrames"}, 32'(bus.droppedFrames), 0);
        check({tag, " repeatedFrames"}, 32'(bus.repeatedFrames), 0);
    endtask

    initial begin
        // eor eow rs rx ry ws wx wy wd | read write drop rep valid pixel
        vecs[0]  = '{0, 0, 1, 3, 1, 0, 0, 0, 0,          0, 1, 0, 0, 1, 32'hFFFFFF};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0,          0, 2, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0,          0, 1, 1, 0, 0, 0};
        vecs[3]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0,          2, 0, 1, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,          1, 0, 1, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,          1, 0, 1, 1, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 1, 2, 1, 32'h123456, 1, 0, 1, 1, 0, 0};
        vecs[7]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0,          1, 2, 1, 1, 0, 0};
        vecs[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,          0, 2, 1, 1, 0, 0};
        vecs[9]  = '{0, 0, 1, 2, 1, 0, 0, 0, 0,          0, 2, 1, 1, 1, 32'h123456};
        vecs[10] = '{0, 0, 1, 3, 1, 0, 0, 0, 0,          0, 2, 1, 1, 1, 32'hFFFFFF};
        vecs[11] = '{0, 0, 1, 5, 0, 0, 0, 0, 0,          0, 2, 1, 1, 1, 0};
        vecs[12] = '{0, 0, 1, 0, 2, 0, 0, 0, 0,          0, 2, 1, 1, 1, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 2, 1, 1, 0, 0};

        for (int i = 0; i < TOTAL; i++) refKnown[i] = 0;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, '0);
        modelReset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");

        // Release away from the edge; strobes held high through INIT must be ignored.
        reset = 1'b1;
        setIn(1, 1, 1, 3, 1, 0, 0, 0, '0);
        for (int k = 1; k <= FRAME + 1; k++) begin
            tick();
            check($sformatf("init edge %0d ableToRead", k), 32'(bus.ableToRead),
                  32'(k == FRAME + 1));
            check($sformatf("init edge %0d ableToWrite", k), 32'(bus.ableToWrite),
                  32'(k == FRAME + 1));
            check($sformatf("init edge %0d readPixelValid", k), 32'(bus.readPixelValid), 0);
            check($sformatf("init edge %0d currentWrite", k), 32'(bus.currentWrite), 1);
        end
        setIn(0, 0, 0, 0, 0, 0, 0, 0, '0);

        for (int i = 0; i < 14; i++) begin
            setIn(vecs[i].eor, vecs[i].eow, vecs[i].rs, vecs[i].rx, vecs[i].ry,
                  vecs[i].ws, vecs[i].wx, vecs[i].wy, PW'(vecs[i].wd));
            tick();
            check($sformatf("vec %0d currentRead", i), 32'(bus.currentRead), vecs[i].eRead);
            check($sformatf("vec %0d currentWrite", i), 32'(bus.currentWrite), vecs[i].eWrite);
            check($sformatf("vec %0d droppedFrames", i), 32'(bus.droppedFrames), vecs[i].eDrop);
            check($sformatf("vec %0d repeatedFrames", i), 32'(bus.repeatedFrames),
                  vecs[i].eRep);
            check($sformatf("vec %0d readPixelValid", i), 32'(bus.readPixelValid),
                  32'(vecs[i].eValid));
            if (vecs[i].eValid)
                check($sformatf("vec %0d readPixel", i), 32'(bus.readPixel), vecs[i].ePixel);
        end

        for (int c = 0; c < 600; c++) begin
            setIn($urandom_range(4, 0) == 0, $urandom_range(4, 0) == 0, $urandom_range(1, 0) == 1,
                  $urandom_range(4, 0), $urandom_range(2, 0), $urandom_range(1, 0) == 1,
                  $urandom_range(4, 0), $urandom_range(2, 0), PW'($urandom));
            tick();
            checkAll($sformatf("rand %0d", c));
        end

        // Re-init, make slot 1 READY with drops recorded, then reset asynchronously mid-frame.
        setIn(0, 0, 0, 0, 0, 0, 0, 0, '0);
        reset = 1'b0;
        modelReset();
        #2 reset = 1'b1;
        repeat (FRAME + 1) tick();
        checkAll("reinit");
        for (int e = 0; e < 3; e++) begin
            setIn(0, 1, 0, 0, 0, 1, e, 0, PW'(32'hA0 + e));
            tick();
            checkAll($sformatf("pre-reset eow %0d", e));
        end
        check("pre-reset droppedFrames", 32'(bus.droppedFrames), 2);
        check("pre-reset currentWrite", 32'(bus.currentWrite), 2);
        setIn(0, 0, 1, 3, 1, 1, 1, 1, 24'h5A5A5A);
        tick();
        checkAll("pre-reset read");
        setIn(0, 0, 0, 0, 0, 0, 0, 0, '0);
        #3 reset = 1'b0;
        modelReset();
        #1;
        checkResetValues("async reset");
        #2 reset = 1'b1;
        for (int k = 1; k <= FRAME + 1; k++) begin
            tick();
            check($sformatf("rerun edge %0d ableToRead", k), 32'(bus.ableToRead),
                  32'(k == FRAME + 1));
        end
        setIn(0, 0, 0, 0, 0, 1, 4, 0, 24'h777777);
        tick();
        checkAll("oor write");
        setIn(0, 0, 1, 4, 0, 0, 0, 0, '0);
        tick();
        check("oor read valid", 32'(bus.readPixelValid), 1);
        check("oor read pixel", 32'(bus.readPixel), 0);
        setIn(0, 0, 1, 3, 1, 0, 0, 0, '0);
        tick();
        check("refilled slot0 pixel", 32'(bus.readPixel), 32'hFFFFFF);
        checkAll("post-rerun");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
